// File: rtl/gptp_rtc.sv
// IEEE 802.1AS real-time clock: fractional-ns free-running counter with
// absolute-load / signed-offset correction via a valid/ready handshake.
module gptp_rtc #(
    parameter logic [25:0] INC_DEFAULT = 26'h0800000,
    parameter int          FRAC_BITS   = 20,
    parameter int          NS_PER_SEC  = 1000000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gptp_vaild,
    output logic        rtc_ready,
    input  logic        gptp_sw,
    input  logic [31:0] syntonised_nanosec_field_r,
    input  logic [31:0] syntonised_sec_field_r,
    input  logic [15:0] syntonised_epoch_field_r,
    input  logic [29:0] nanosec_offset,
    input  logic [31:0] sec_offset,
    input  logic [15:0] epoch_offset,
    input  logic [25:0] rtc_increment,
    output logic [31:0] rtc_nanosec_field,
    output logic [31:0] rtc_sec_field,
    output logic [15:0] rtc_epoch_field,
    output logic        rtc_pps,
    output logic        rtc_update_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_APPLY  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    // accumulator width: 1 guard bit + 30 ns bits + fraction
    localparam int AW = 31 + FRAC_BITS;
    localparam logic [30:0] NS31 = 31'(NS_PER_SEC);
    localparam logic [31:0] NS32 = 32'(NS_PER_SEC);
    localparam logic [32:0] NS33 = 33'(NS_PER_SEC);

    logic [1:0]           state;
    logic                 ready_q, pps_q, err_q;
    logic [29:0]          ns_q;
    logic [FRAC_BITS-1:0] frac_q;
    logic [47:0]          sec_q;
    logic [25:0]          inc_reg;

    logic                 sw_q;
    logic [31:0]          ld_ns_q;
    logic [47:0]          ld_sec_q;
    logic [29:0]          off_ns_q;
    logic [47:0]          off_sec_q;

    logic [AW-1:0]        inc_ext, tick_sum, ld_sum;
    logic [30:0]          tick_ns, ld_ns_t;
    logic                 tick_roll, ld_roll, ld_ok;
    logic [32:0]          off_s;
    logic                 off_neg, off_ovf;

    logic [29:0]          ns_nxt;
    logic [FRAC_BITS-1:0] frac_nxt;
    logic [47:0]          sec_nxt;
    logic                 pps_nxt, err_nxt;

    assign inc_ext  = {{(AW-26){1'b0}}, inc_reg};
    assign tick_sum = {1'b0, ns_q, frac_q} + inc_ext;
    assign tick_ns  = tick_sum[AW-1:FRAC_BITS];
    assign tick_roll = (tick_ns >= NS31);

    // absolute load: fraction cleared, then one tick on top of the load value
    assign ld_ok   = (ld_ns_q < NS32);
    assign ld_sum  = {1'b0, ld_ns_q[29:0], {FRAC_BITS{1'b0}}} + inc_ext;
    assign ld_ns_t = ld_sum[AW-1:FRAC_BITS];
    assign ld_roll = (ld_ns_t >= NS31);

    // offset: signed sum of ticked ns and the offset; range fits 33 bits
    assign off_s   = {2'b00, tick_ns} + {{3{off_ns_q[29]}}, off_ns_q};
    assign off_neg = off_s[32];
    assign off_ovf = !off_s[32] && (off_s >= NS33);

    always_comb begin
        ns_nxt   = tick_roll ? 30'(tick_ns - NS31) : tick_ns[29:0];
        frac_nxt = tick_sum[FRAC_BITS-1:0];
        sec_nxt  = sec_q + 48'(tick_roll);
        pps_nxt  = tick_roll;
        err_nxt  = 1'b0;
        if (state == S_APPLY) begin
            if (sw_q) begin
                if (ld_ok) begin
                    ns_nxt   = ld_roll ? 30'(ld_ns_t - NS31) : ld_ns_t[29:0];
                    frac_nxt = ld_sum[FRAC_BITS-1:0];
                    sec_nxt  = ld_sec_q + 48'(ld_roll);
                    pps_nxt  = ld_roll;
                end else begin
                    err_nxt  = 1'b1;
                end
            end else begin
                pps_nxt = 1'b0;
                if (off_neg) begin
                    ns_nxt  = 30'(off_s + NS33);
                    sec_nxt = sec_q + off_sec_q - 48'd1;
                end else if (off_ovf) begin
                    ns_nxt  = 30'(off_s - NS33);
                    sec_nxt = sec_q + off_sec_q + 48'd1;
                end else begin
                    ns_nxt  = off_s[29:0];
                    sec_nxt = sec_q + off_sec_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            ready_q   <= 1'b0;
            pps_q     <= 1'b0;
            err_q     <= 1'b0;
            ns_q      <= '0;
            frac_q    <= '0;
            sec_q     <= '0;
            inc_reg   <= INC_DEFAULT;
            sw_q      <= 1'b0;
            ld_ns_q   <= '0;
            ld_sec_q  <= '0;
            off_ns_q  <= '0;
            off_sec_q <= '0;
        end else begin
            ns_q   <= ns_nxt;
            frac_q <= frac_nxt;
            sec_q  <= sec_nxt;
            pps_q  <= pps_nxt;
            err_q  <= err_nxt;
            case (state)
                S_IDLE: begin
                    if (gptp_vaild && ready_q) begin
                        sw_q      <= gptp_sw;
                        ld_ns_q   <= syntonised_nanosec_field_r;
                        ld_sec_q  <= {syntonised_epoch_field_r, syntonised_sec_field_r};
                        off_ns_q  <= nanosec_offset;
                        off_sec_q <= {epoch_offset, sec_offset};
                        inc_reg   <= rtc_increment;
                        state     <= S_APPLY;
                        ready_q   <= 1'b0;
                    end else begin
                        ready_q   <= 1'b1;
                    end
                end
                S_APPLY: begin
                    state   <= S_SETTLE;
                    ready_q <= 1'b0;
                end
                S_SETTLE: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign rtc_ready         = ready_q;
    assign rtc_pps           = pps_q;
    assign rtc_update_err    = err_q;
    assign rtc_nanosec_field = {2'b00, ns_q};
    assign rtc_sec_field     = sec_q[31:0];
    assign rtc_epoch_field   = sec_q[47:32];

endmodule

// File: doc/gptp_rtc.md
Name: gptp_rtc

Overview:
- Free-running IEEE 802.1AS real-time clock that directly consumes the correction outputs of the gptp2 protocol engine.
- Inputs from gptp2: gptp_vaild, gptp_sw, syntonised_*_r, *_offset, rtc_increment.
- Outputs to gptp2: the sampled time rtc_nanosec_field, rtc_sec_field, rtc_epoch_field, and the rtc_ready handshake.
- Advances time every clk by a fractional-nanosecond increment. Applies either an absolute time load or a signed offset through a valid/ready handshake.

Parameters:
- INC_DEFAULT, 26'h0800000, reset increment: 8.0 ns per cycle at 125 MHz, Q6.20 format.
- FRAC_BITS, 20, fractional bits of the increment and accumulator.
- NS_PER_SEC, 1000000000, nanosecond rollover value.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- gptp_vaild  in  1  update request from gptp2.
- rtc_ready  out  1  block can accept an update.
- gptp_sw  in  1  1 = absolute load, 0 = offset adjust.
- syntonised_nanosec_field_r  in  32  load value, ns.
- syntonised_sec_field_r  in  32  load value, seconds.
- syntonised_epoch_field_r  in  16  load value, seconds bits [47:32].
- nanosec_offset  in  30  signed two's-complement ns offset.
- sec_offset  in  32  seconds offset, low part of a signed 48-bit {epoch_offset,sec_offset}.
- epoch_offset  in  16  seconds offset, high part.
- rtc_increment  in  26  Q6.20 ns per clk, captured on accept.
- rtc_nanosec_field  out  32  current ns; bits [31:30] always 0.
- rtc_sec_field  out  32  current seconds [31:0].
- rtc_epoch_field  out  16  current seconds [47:32].
- rtc_pps  out  1  one-cycle pulse on a natural seconds rollover.
- rtc_update_err  out  1  one-cycle pulse when an absolute load is rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - ns, sec, epoch and the 20-bit fraction = 0.
  - inc_reg = INC_DEFAULT.
  - rtc_ready = 0, rtc_pps = 0, rtc_update_err = 0.
  - State = IDLE.
  - rtc_ready goes 1 on the first clk edge after reset is released.
- Tick, every edge not in APPLY:
  - {ns,frac} += inc_reg.
  - If ns >= NS_PER_SEC: ns -= NS_PER_SEC, 48-bit seconds += 1, and rtc_pps = 1 on the next cycle.
  - {epoch,sec} wraps modulo 2^48 with no flag (sec FFFFFFFF carries into epoch).
- State machine IDLE -> APPLY -> SETTLE -> IDLE.
  - IDLE: rtc_ready = 1. Accept when gptp_vaild && rtc_ready at an edge:
    - capture gptp_sw, all load/offset operands, and rtc_increment into inc_reg;
    - go to APPLY.
  - APPLY (rtc_ready = 0): the edge leaving APPLY writes time as below; go to SETTLE. The tick at this edge uses the new inc_reg.
    - Absolute, sw=1, load ns < NS_PER_SEC: time = load value + one tick; fraction cleared before the tick.
    - Absolute with load ns >= NS_PER_SEC: load rejected; normal tick only; rtc_update_err pulses for 1 cycle.
    - Offset, sw=0: s = ns + sign-extended nanosec_offset + tick integer part.
      - If s < 0: ns = s + NS_PER_SEC and seconds borrow 1.
      - If s >= NS_PER_SEC: ns = s - NS_PER_SEC and seconds carry 1.
      - One correction always suffices.
      - seconds += {epoch_offset,sec_offset} mod 2^48; fraction retained.
    - rtc_pps never pulses for seconds changes made by a load or offset.
  - SETTLE: rtc_ready = 0, normal tick, go to IDLE. Guarantees gptp2 samples corrected time before its next request.
- gptp_vaild held high is accepted again at the first IDLE edge, giving a minimum 3-cycle update period.
- Operands are ignored outside the accept edge.
- Reset asserted mid-APPLY/SETTLE aborts the update; all reset values apply.

Test Plan:
- Rollover: load ns=999,999,976, sec=7, inc 8.0 -> ns 999,999,984, 999,999,992, then ns=0 sec=8; rtc_pps high exactly 1 cycle.
- Fractional increment: inc=26'h0880000 (8.5 ns), load ns=0 -> ns sequence 8, 17, 25, 34 on successive edges.
- Absolute load handshake: sw=1, syntonised ns=100 sec=5 epoch=1, inc 8 -> after APPLY edge ns=108 sec=5 epoch=1; rtc_ready low exactly 2 cycles (APPLY, SETTLE).
- Negative offset: time ns=100 sec=10, nanosec_offset=30'h3FFFFF38 (-200), sec/epoch offset 0 -> ns=999,999,908, sec=9, no pps.
- Epoch carry: load sec=32'hFFFFFFFF ns=999,999,992 epoch=2 -> next tick sec=0 epoch=3, rtc_pps=1.
- Invalid load then reset: sw=1 ns=1,000,000,000 -> rtc_update_err 1-cycle pulse, time only ticks. Then assert reset during APPLY -> all outputs 0, rtc_ready 0, and rtc_ready returns 1 one edge after release.
